// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter and its helpers.
package fifo_wr_arbiter_pkg;

    // Arbiter FSM state encoding.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Index width for n requesters; at least one bit so n==1 stays legal.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first set request found searching
// upward from last+1 with wrap-around. Produces a one-hot pick and its index.
module rr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]        req,
    input  logic [idx_w(N_REQ)-1:0] last,
    output logic [N_REQ-1:0]        pick,
    output logic [idx_w(N_REQ)-1:0] idx
);

    localparam int IDXW = idx_w(N_REQ);

    logic            found;
    logic [IDXW-1:0] cand;

    // Scan the requesters in rotated priority order; the first hit wins.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDXW'((int'(last) + k) % N_REQ);
            if (!found && req[cand]) begin
                found      = 1'b1;
                pick[cand] = 1'b1;
                idx        = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port between N_REQ producers.
// Grants bursts of up to BURST_MAX beats and never writes while wr_full is high.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no grant; arbitrate among valid requesters (one-cycle bubble)
//   ST_GRANT | gnt holds one requester; beats flow while valid and not full
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            in_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] in_data,
    output logic [N_REQ-1:0]            in_ready,
    input  logic                        wr_full,
    output logic                        wr_en,
    output logic [DATA_WIDTH-1:0]       wr_data,
    output logic [N_REQ-1:0]            gnt,
    output logic                        busy
);

    localparam int IDXW = idx_w(N_REQ);
    localparam int CW   = $clog2(BURST_MAX + 1);

    state_t          state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDXW-1:0] gidx_q, gidx_d;
    logic [IDXW-1:0] rr_last_q, rr_last_d;
    logic [CW-1:0]   burst_cnt_q, burst_cnt_d;

    logic [N_REQ-1:0] pick;
    logic [IDXW-1:0]  pick_idx;
    logic             beat;
    logic             last_beat;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr (
        .req  (in_valid),
        .last (rr_last_q),
        .pick (pick),
        .idx  (pick_idx)
    );

    // Write path: a beat needs a live grant, granted valid, room in the FIFO,
    // and no reset this cycle so nothing is accepted that reset then forgets.
    always_comb begin
        beat      = (state_q == ST_GRANT) & in_valid[gidx_q] & ~wr_full & ~rst;
        last_beat = beat & (burst_cnt_q == CW'(BURST_MAX - 1));
        wr_en     = beat;
        in_ready  = {N_REQ{beat}} & gnt_q;
        wr_data   = in_data[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];
        gnt       = gnt_q;
        busy      = (state_q == ST_GRANT);
    end

    // Next-state logic: arbitrate in IDLE, count beats and release in GRANT.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gidx_d      = gidx_q;
        rr_last_d   = rr_last_q;
        burst_cnt_d = burst_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|in_valid) begin
                    state_d     = ST_GRANT;
                    gnt_d       = pick;
                    gidx_d      = pick_idx;
                    burst_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                if (!in_valid[gidx_q] || last_beat) begin
                    state_d     = ST_IDLE;
                    gnt_d       = '0;
                    rr_last_d   = gidx_q;
                    burst_cnt_d = '0;
                end else if (beat) begin
                    burst_cnt_d = burst_cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset; requester 0 wins first after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            gidx_q      <= '0;
            rr_last_q   <= IDXW'(N_REQ - 1);
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gidx_q      <= gidx_d;
            rr_last_q   <= rr_last_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed phases plus randomized
// traffic, compared every cycle against a transaction-level reference model.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BM = 4;

    logic          clk;
    logic          rst;
    logic [N-1:0]  in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]  in_ready;
    logic          wr_full;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic [N-1:0]  gnt;
    logic          busy;

    fifo_wr_arbiter #(
        .N_REQ      (N),
        .DATA_WIDTH (DW),
        .BURST_MAX  (BM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_full  (wr_full),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .gnt      (gnt),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: owner of the write port (-1 = nobody), beats taken in
    // the current grant, and the most recently released requester.
    int cur   = -1;
    int beats = 0;
    int last  = N - 1;
    int seq [N];   // next word each producer will offer

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Lowest rotated distance from last+1 wins.
    function automatic int rr_choose(input logic [N-1:0] v, input int lst);
        int best  = -1;
        int bestd = N;
        for (int i = 0; i < N; i++) begin
            int d = (i - lst - 1 + 2 * N) % N;
            if (v[i] && d < bestd) begin
                bestd = d;
                best  = i;
            end
        end
        return best;
    endfunction

    function automatic logic [DW-1:0] word_of(input int r, input int s);
        return DW'(r * 64 + (s % 64));
    endfunction

    task automatic cycle(input logic r, input logic [N-1:0] v, input logic f);
        logic         exp_beat;
        logic [N-1:0] exp_gnt;
        rst      = r;
        in_valid = v;
        wr_full  = f;
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = word_of(i, seq[i]);
        @(negedge clk);
        exp_beat = (cur >= 0) && v[cur] && !f && !r;
        exp_gnt  = (cur >= 0) ? N'(1 << cur) : '0;
        chk("gnt",      32'(gnt),      32'(exp_gnt));
        chk("busy",     32'(busy),     32'(cur >= 0));
        chk("wr_en",    32'(wr_en),    32'(exp_beat));
        chk("in_ready", 32'(in_ready), exp_beat ? 32'(exp_gnt) : 32'd0);
        if (exp_beat) chk("wr_data", 32'(wr_data), 32'(word_of(cur, seq[cur])));
        @(posedge clk);
        if (r) begin
            cur   = -1;
            beats = 0;
            last  = N - 1;
        end else if (cur < 0) begin
            if (v != '0) begin
                cur   = rr_choose(v, last);
                beats = 0;
            end
        end else if (!v[cur]) begin
            last = cur;
            cur  = -1;
        end else if (exp_beat) begin
            seq[cur]++;
            beats++;
            if (beats == BM) begin
                last = cur;
                cur  = -1;
            end
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) seq[i] = 0;
        rst      = 1'b1;
        in_valid = '1;
        wr_full  = 1'b0;
        in_data  = '0;
        @(posedge clk);
        #1;
        // reset held with every requester valid
        cycle(1'b1, 4'hF, 1'b0);
        // lone requester 2: bursts of four with a bubble between
        repeat (20) cycle(1'b0, 4'b0100, 1'b0);
        cycle(1'b1, 4'h0, 1'b0);
        // all valid: rotating grants 0,1,2,3,0...
        repeat (26) cycle(1'b0, 4'hF, 1'b0);
        cycle(1'b1, 4'h0, 1'b0);
        // requester 0 with the FIFO going full at times
        repeat (3) cycle(1'b0, 4'b0001, 1'b0);
        repeat (3) cycle(1'b0, 4'b0001, 1'b1);
        repeat (8) cycle(1'b0, 4'b0001, 1'b0);
        repeat (30) cycle(1'b0, 4'b0001, 1'($urandom_range(0, 2) == 0));
        // requester 1 drops after one beat while 3 waits
        cycle(1'b0, 4'b1010, 1'b0);
        cycle(1'b0, 4'b1010, 1'b0);
        cycle(1'b0, 4'b1000, 1'b0);
        repeat (4) cycle(1'b0, 4'b1000, 1'b0);
        // reset in the middle of a requester-1 burst, then all valid
        cycle(1'b1, 4'h0, 1'b0);
        repeat (3) cycle(1'b0, 4'b0010, 1'b0);
        cycle(1'b1, 4'b0010, 1'b0);
        repeat (4) cycle(1'b0, 4'hF, 1'b0);
        // random traffic, full and valid drops
        repeat (300) cycle(1'b0, 4'($urandom), 1'($urandom_range(0, 3) == 0));
        // random traffic with occasional resets
        repeat (300) cycle(1'($urandom_range(0, 24) == 0), 4'($urandom),
                           1'($urandom_range(0, 4) == 0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
